// File: rtl/full_adder_pkg.sv
`default_nettype none
// ============================================================================
// full_adder_pkg : shared constants and per-bit full-adder equations.
// Revision: 1.0
// ============================================================================
package full_adder_pkg;

    localparam int FA_DEFAULT_WIDTH = 1;

    function automatic logic fa_sum(input logic a, input logic b, input logic ci);
        return a ^ b ^ ci;
    endfunction

    function automatic logic fa_carry(input logic a, input logic b, input logic ci);
        return (a & b) | (ci & (a ^ b));
    endfunction

endpackage : full_adder_pkg
`default_nettype wire

// File: rtl/full_adder_bit.sv
`default_nettype none
// ============================================================================
// full_adder_bit : one-bit full adder cell, the link of the ripple chain.
// Revision: 1.0
// ============================================================================
module full_adder_bit
    import full_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = fa_sum(a, b, ci);
    assign co = fa_carry(a, b, ci);

endmodule : full_adder_bit
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// full_adder : WIDTH-bit ripple-carry adder with combinational and
//              registered (1-cycle, in_valid-qualified) result outputs.
// Revision: 1.0
// ============================================================================
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH = FA_DEFAULT_WIDTH
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    output logic             carry,
    output logic [WIDTH-1:0] sum,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum_q,
    output logic             carry_q,
    output logic             out_valid
);

    logic [WIDTH:0]   w_ci;
    logic [WIDTH-1:0] r_sum_q;
    logic             r_carry_q;
    logic             r_out_valid;

    assign w_ci[0] = c;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            full_adder_bit u_bit (
                .a  (a[i]),
                .b  (b[i]),
                .ci (w_ci[i]),
                .s  (sum[i]),
                .co (w_ci[i+1])
            );
        end
    endgenerate

    assign carry = w_ci[WIDTH];

    // Result registers hold when in_valid is low; only the valid flag tracks every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum_q     <= '0;
            r_carry_q   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_sum_q   <= sum;
                r_carry_q <= carry;
            end
        end
    end

    assign sum_q     = r_sum_q;
    assign carry_q   = r_carry_q;
    assign out_valid = r_out_valid;

endmodule : full_adder
`default_nettype wire

// File: tb/tb_full_adder.sv
`default_nettype none
// ============================================================================
// tb_full_adder : vector table for the combinational path, scoreboard for the
//                 registered path, on WIDTH=1 and WIDTH=8 instances.
// Revision: 1.0
// ============================================================================
module tb_full_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [0:0] a1, b1, sum1, sum_q1;
    logic       c1, carry1, carry_q1, ov1;
    logic [7:0] a8, b8, sum8, sum_q8;
    logic       c8, carry8, carry_q8, ov8;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    full_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .c(c1),
        .carry(carry1), .sum(sum1), .in_valid(in_valid),
        .sum_q(sum_q1), .carry_q(carry_q1), .out_valid(ov1)
    );

    full_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .c(c8),
        .carry(carry8), .sum(sum8), .in_valid(in_valid),
        .sum_q(sum_q8), .carry_q(carry_q8), .out_valid(ov8)
    );

    typedef struct {
        bit         w8;
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [8:0] exp;
    } vec_t;

    typedef struct {
        logic [8:0] r8;
        logic [1:0] r1;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    sb_t  hold;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_regs_zero(input string tag);
        check({tag, "_sum_q8"},   {24'd0, sum_q8},  32'd0);
        check({tag, "_carry_q8"}, {31'd0, carry_q8}, 32'd0);
        check({tag, "_ov8"},      {31'd0, ov8},      32'd0);
        check({tag, "_sum_q1"},   {31'd0, sum_q1},   32'd0);
        check({tag, "_carry_q1"}, {31'd0, carry_q1}, 32'd0);
        check({tag, "_ov1"},      {31'd0, ov1},      32'd0);
    endtask

    // One clock of the registered path: drive at negedge, compare just after posedge.
    task automatic cycle(input logic v, input logic [7:0] av8, input logic [7:0] bv8,
                         input logic cv8, input logic av1, input logic bv1, input logic cv1);
        sb_t e;
        @(negedge clk);
        a8 = av8; b8 = bv8; c8 = cv8;
        a1 = av1; b1 = bv1; c1 = cv1;
        in_valid = v;
        if (v) begin
            e.r8 = {1'b0, av8} + {1'b0, bv8} + {8'd0, cv8};
            e.r1 = {1'b0, av1} + {1'b0, bv1} + {1'b0, cv1};
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        check("out_valid8", {31'd0, ov8}, {31'd0, v});
        check("out_valid1", {31'd0, ov1}, {31'd0, v});
        if (v) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_underflow: got empty queue required one entry");
            end else begin
                hold = sb.pop_front();
            end
        end
        check("reg8", {23'd0, carry_q8, sum_q8}, {23'd0, hold.r8});
        check("reg1", {30'd0, carry_q1, sum_q1}, {30'd0, hold.r1});
    endtask

    initial begin
        vec_t v;
        rst_n = 1'b1; in_valid = 1'b0;
        a1 = '0; b1 = '0; c1 = 1'b0;
        a8 = '0; b8 = '0; c8 = 1'b0;
        hold.r8 = '0; hold.r1 = '0;

        // Reset takes effect with no clock edge in between.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_regs_zero("rst_async");

        vecs.push_back('{1'b0, 8'd1, 8'd1, 1'b1, 9'd3});
        vecs.push_back('{1'b0, 8'd0, 8'd0, 1'b1, 9'd1});
        vecs.push_back('{1'b0, 8'd1, 8'd0, 1'b1, 9'd2});
        vecs.push_back('{1'b0, 8'd0, 8'd0, 1'b0, 9'd0});
        for (int i = 0; i < 8; i++) begin
            v.w8  = 1'b0;
            v.a   = {7'd0, i[2]};
            v.b   = {7'd0, i[1]};
            v.c   = i[0];
            v.exp = 9'(i[2]) + 9'(i[1]) + 9'(i[0]);
            vecs.push_back(v);
        end
        vecs.push_back('{1'b1, 8'hFF, 8'h01, 1'b0, 9'h100});
        vecs.push_back('{1'b1, 8'hFF, 8'hFF, 1'b1, 9'h1FF});
        vecs.push_back('{1'b1, 8'h00, 8'h00, 1'b0, 9'h000});
        vecs.push_back('{1'b1, 8'hAA, 8'h55, 1'b1, 9'h100});
        vecs.push_back('{1'b1, 8'h80, 8'h80, 1'b0, 9'h100});
        vecs.push_back('{1'b1, 8'h3C, 8'h0F, 1'b1, 9'h04C});

        // Combinational path exercised while reset is held low.
        foreach (vecs[k]) begin
            if (vecs[k].w8) begin
                a8 = vecs[k].a; b8 = vecs[k].b; c8 = vecs[k].c;
                #20;
                check($sformatf("comb8_%0d", k), {23'd0, carry8, sum8}, {23'd0, vecs[k].exp});
            end else begin
                a1 = vecs[k].a[0:0]; b1 = vecs[k].b[0:0]; c1 = vecs[k].c;
                #20;
                check($sformatf("comb1_%0d", k), {30'd0, carry1, sum1}, {23'd0, vecs[k].exp});
            end
        end
        check_regs_zero("rst_held");

        @(negedge clk);
        rst_n = 1'b1;

        cycle(1'b1, 8'hFF, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 8'h12, 8'h34, 1'b1, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 30; i++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom));
        end

        // Mid-stream reset clears registers asynchronously and holds through an edge.
        cycle(1'b1, 8'hF0, 8'h0F, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        in_valid = 1'b1;
        #1;
        check_regs_zero("rst_mid");
        @(posedge clk);
        #1;
        check_regs_zero("rst_mid_edge");
        hold.r8 = '0; hold.r1 = '0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;

        cycle(1'b0, 8'h55, 8'h55, 1'b0, 1'b1, 1'b1, 1'b1);
        cycle(1'b1, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 8'h01, 1'b1, 1'b1, 1'b1, 1'b0);

        check("sb_empty", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_full_adder
`default_nettype wire
